// File: rtl/backscatter_pkg.sv
// Shared definitions for the backscatter modulator: FSM state encoding,
// parameter defaults and a counter-width helper.
package backscatter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2
    } state_t;

    localparam int DATA_W_DEF        = 8;
    localparam int SHIFT_HALF_DEF    = 1;
    localparam int PREAMBLE_SYMS_DEF = 4;

    // Width of a counter spanning 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/backscatter_modulator_if.sv
// Payload stream into the modulator: valid/ready handshake carrying a word
// and an end-of-frame flag.
interface backscatter_modulator_if
    import backscatter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;

    // Tag-data source side.
    modport master (
        output in_data,
        output in_valid,
        output in_last,
        input  in_ready
    );

    // Modulator side.
    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/backscatter_modulator_sym_edge_detect.sv
// Rising-edge detector for the symbol clock. sym_clk is treated as data in
// the clock_in domain; o_tick is high for the one cycle in which sym_clk is
// high but was low on the previous edge.
module sym_edge_detect (
    input  logic clock_in,
    input  logic reset,
    input  logic i_sym_clk,
    output logic o_tick
);

    logic r_sym_clk_q;

    // Delay sym_clk by one cycle for edge comparison.
    always_ff @(posedge clock_in) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (reset) begin
            r_sym_clk_q <= 1'b0;
        end else begin
            r_sym_clk_q <= i_sym_clk;
        end
    end

    assign o_tick = i_sym_clk & ~r_sym_clk_q;

endmodule

// File: rtl/backscatter_modulator.sv
// Codeword-translation backscatter modulator. Buffers one payload word,
// sends PREAMBLE_SYMS reference symbols, then serialises payload bits
// MSB-first at one bit per symbol tick. The RF switch is driven with a
// square wave whose phase is inverted for data bit 1.
module backscatter_modulator
    import backscatter_pkg::*;
#(
    parameter int SHIFT_HALF    = SHIFT_HALF_DEF,
    parameter int PREAMBLE_SYMS = PREAMBLE_SYMS_DEF,
    parameter int DATA_W        = DATA_W_DEF
) (
    input  logic                          clock_in,
    input  logic                          reset,
    input  logic                          sym_clk,
    backscatter_modulator_if.slave        in_if,
    output logic                          rf_switch,
    output logic                          busy,
    output logic                          done,
    output logic                          underrun
);

    localparam int CAR_W = cnt_width(SHIFT_HALF);
    localparam int IDX_W = cnt_width(DATA_W);

    // Symbol tick and control strobes.
    logic w_tick;
    logic w_accept;
    logic w_pre_last;
    logic w_word_end;
    logic w_load;
    logic w_to_idle;

    // Holding register (one word of look-ahead).
    logic [DATA_W-1:0] r_hold_data;
    logic              r_hold_last;
    logic              r_hold_full;

    // Frame sequencing.
    state_t            r_state;
    logic [7:0]        r_pre_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [IDX_W-1:0]  r_bit_idx;
    logic              r_cur_last;
    logic              r_done;
    logic              r_underrun;

    // Shift-frequency carrier and output.
    logic [CAR_W-1:0]  r_car_cnt;
    logic              r_carrier;
    logic              r_rf;

    sym_edge_detect u_sym_edge (
        .clock_in  (clock_in),
        .reset     (reset),
        .i_sym_clk (sym_clk),
        .o_tick    (w_tick)
    );

    // Ready tracks the empty holding register, forced low while in reset.
    assign in_if.in_ready = ~r_hold_full & ~reset;
    assign w_accept       = in_if.in_valid & in_if.in_ready;

    // Decode the tick-qualified load and end-of-frame events.
    always_comb begin
        // NOTE: every output of this block gets a value before any branch,
        // so no path can leave one unassigned and infer a latch.
        w_pre_last = (r_pre_cnt == 8'(PREAMBLE_SYMS - 1));
        w_word_end = w_tick && (r_state == ST_DATA) && (r_bit_idx == '0);
        w_load     = 1'b0;
        w_to_idle  = 1'b0;
        if (w_tick && (r_state == ST_PREAMBLE) && w_pre_last) begin
            w_load = 1'b1;
        end
        if (w_word_end) begin
            if (r_cur_last) begin
                w_to_idle = 1'b1;
            end else if (r_hold_full) begin
                w_load = 1'b1;
            end else begin
                w_to_idle = 1'b1;
            end
        end
    end

    // Holding register: fill on accept, drain when the shifter loads.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_hold_full <= 1'b0;
            r_hold_data <= '0;
            r_hold_last <= 1'b0;
        end else if (w_accept) begin
            r_hold_full <= 1'b1;
            r_hold_data <= in_if.in_data;
            r_hold_last <= in_if.in_last;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end
    end

    // Frame FSM: preamble count, bit serialisation and end-of-frame pulses.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pre_cnt  <= '0;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_cur_last <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    ST_IDLE: begin
                        if (r_hold_full) begin
                            r_state   <= ST_PREAMBLE;
                            r_pre_cnt <= '0;
                            r_shift   <= '0;  // reference symbols are bit 0
                        end
                    end
                    ST_PREAMBLE: begin
                        if (w_pre_last) begin
                            r_state <= ST_DATA;
                        end else begin
                            r_pre_cnt <= r_pre_cnt + 8'd1;
                        end
                    end
                    ST_DATA: begin
                        if (r_bit_idx != '0) begin
                            r_shift   <= r_shift << 1;
                            r_bit_idx <= r_bit_idx - 1'b1;
                        end else if (w_to_idle) begin
                            r_state    <= ST_IDLE;
                            r_done     <= r_cur_last;
                            r_underrun <= ~r_cur_last;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
            if (w_load) begin
                r_shift    <= r_hold_data;
                r_bit_idx  <= IDX_W'(DATA_W - 1);
                r_cur_last <= r_hold_last;
            end
        end
    end

    // Carrier: free-running half-period counter while busy, parked at 0 otherwise.
    always_ff @(posedge clock_in) begin
        if (reset || (r_state == ST_IDLE) || w_to_idle) begin
            r_car_cnt <= '0;
            r_carrier <= 1'b0;
        end else if (r_car_cnt == CAR_W'(SHIFT_HALF - 1)) begin
            r_car_cnt <= '0;
            r_carrier <= ~r_carrier;
        end else begin
            r_car_cnt <= r_car_cnt + 1'b1;
        end
    end

    // Registered RF drive: carrier phase-flipped by the current bit (MSB of the shifter).
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_rf <= 1'b0;
        end else if (r_state != ST_IDLE) begin
            r_rf <= r_carrier ^ r_shift[DATA_W-1];
        end else begin
            r_rf <= 1'b0;
        end
    end

    assign rf_switch = r_rf;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign underrun  = r_underrun;

endmodule
